// File: rtl/instruction_buffer_pkg.sv
// Shared constants for the instruction path: word width and default FIFO sizing.
package instruction_buffer_pkg;
    localparam int unsigned INSTR_WORD_BITS     = 32;
    localparam int unsigned FIFO_DEPTH_DEFAULT  = 16;
    localparam int unsigned FIFO_ADDR_DEFAULT   = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/instruction_buffer_if.sv
// HPS/control-unit facing signals of the instruction buffer.
interface instruction_buffer_if
    import instruction_buffer_pkg::*;
#(
    parameter int unsigned DATA_BITS = INSTR_WORD_BITS,
    parameter int unsigned ADDR_BITS = FIFO_ADDR_DEFAULT
);
    logic                 wrreg;
    logic [DATA_BITS-1:0] in_dataA;
    logic [DATA_BITS-1:0] in_dataB;
    logic                 clr_overflow;
    logic                 rdreg;
    logic [DATA_BITS-1:0] dataA;
    logic [DATA_BITS-1:0] dataB;
    logic                 rdempty;
    logic                 wrfull;
    logic [ADDR_BITS:0]   usedw;
    logic                 overflow;

    modport master (
        output wrreg, in_dataA, in_dataB, clr_overflow, rdreg,
        input  dataA, dataB, rdempty, wrfull, usedw, overflow
    );

    modport slave (
        input  wrreg, in_dataA, in_dataB, clr_overflow, rdreg,
        output dataA, dataB, rdempty, wrfull, usedw, overflow
    );
endinterface

// File: rtl/instruction_buffer_sync_fifo.sv
// Single-clock FIFO with registered occupancy/flags and first-word-fall-through head.
module sync_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_data,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [ADDR_BITS:0]   o_usedw,
    output logic                 o_drop
);
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_usedw;
    logic                 r_empty;
    logic                 r_full;
    logic                 w_pop;
    logic                 w_push;
    logic [ADDR_BITS:0]   w_usedw_nxt;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_pop  = i_pop & ~r_empty;
    assign w_push = i_push & (~r_full | w_pop);
    assign o_drop = i_push & ~w_push;

    always_comb begin
        w_usedw_nxt = r_usedw;
        case ({w_push, w_pop})
            2'b10:   w_usedw_nxt = r_usedw + 1'b1;
            2'b01:   w_usedw_nxt = r_usedw - 1'b1;
            default: w_usedw_nxt = r_usedw;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_usedw <= w_usedw_nxt;
            r_empty <= (w_usedw_nxt == '0);
            r_full  <= (w_usedw_nxt == (ADDR_BITS+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_usedw = r_usedw;
endmodule

// File: rtl/instruction_buffer.sv
// Instruction FIFO feeding video_processor: wrreg synchronizer, edge-detected push, sticky overflow.
module instruction_buffer
    import instruction_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_BITS   = FIFO_ADDR_DEFAULT,
    parameter int unsigned DATA_BITS   = INSTR_WORD_BITS,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    instruction_buffer_if.slave bus
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_overflow;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_empty;
    logic                   w_full;
    logic [ADDR_BITS:0]     w_usedw;
    logic [2*DATA_BITS-1:0] w_head;

    // Chain and history reset high so a strobe held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync     <= '1;
            r_prev     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.wrreg};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (w_drop)                r_overflow <= 1'b1;
            else if (bus.clr_overflow) r_overflow <= 1'b0;
        end
    end

    assign w_push = r_sync[SYNC_STAGES-1] & ~r_prev;

    sync_fifo #(
        .WIDTH     (2*DATA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (bus.rdreg),
        .i_data  ({bus.in_dataA, bus.in_dataB}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_usedw (w_usedw),
        .o_drop  (w_drop)
    );

    assign bus.dataA    = w_empty ? '0 : w_head[2*DATA_BITS-1 -: DATA_BITS];
    assign bus.dataB    = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign bus.rdempty  = w_empty;
    assign bus.wrfull   = w_full;
    assign bus.usedw    = w_usedw;
    assign bus.overflow = r_overflow;
endmodule
